// File: rtl/byte_write_pkg.sv
// Shared constants and requester identifiers for the byte-write arbiter slice.
package byte_write_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned N_WORDS = 4;
    localparam int unsigned ADDR_W  = 2;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/byte_en_word.sv
// One storage word with per-byte-lane write enables and synchronous clear.
module byte_en_word #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] byteena_i,
    input  logic [DATA_W-1:0]   d_i,
    output logic [DATA_W-1:0]   q_o
);

    logic [DATA_W-1:0] word_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            word_q <= '0;
        end else if (we_i) begin
            for (int unsigned k = 0; k < DATA_W / 8; k++) begin
                if (byteena_i[k]) begin
                    word_q[8*k +: 8] <= d_i[8*k +: 8];
                end
            end
        end
    end

    assign q_o = word_q;

endmodule

// File: rtl/byte_write_arbiter.sv
// Two-requester round-robin arbiter in front of a small byte-writable word store,
// with a registered read port and a saturating count of contended cycles.
module byte_write_arbiter #(
    parameter int unsigned DATA_W  = byte_write_pkg::DATA_W,
    parameter int unsigned N_WORDS = byte_write_pkg::N_WORDS,
    parameter int unsigned ADDR_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                a_valid_i,
    output logic                a_ready_o,
    input  logic [ADDR_W-1:0]   a_addr_i,
    input  logic [DATA_W/8-1:0] a_byteena_i,
    input  logic [DATA_W-1:0]   a_data_i,

    input  logic                b_valid_i,
    output logic                b_ready_o,
    input  logic [ADDR_W-1:0]   b_addr_i,
    input  logic [DATA_W/8-1:0] b_byteena_i,
    input  logic [DATA_W-1:0]   b_data_i,

    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic [7:0]          conflict_cnt_o
);

    import byte_write_pkg::*;

    localparam int unsigned BeW = DATA_W / 8;

    req_id_e ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [BeW-1:0]    wr_be;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] word_q [N_WORDS];

    // Grant is held low throughout reset so nothing is accepted.
    assign a_ready_o = resetn & a_valid_i & (~b_valid_i | (ptr_q == REQ_A));
    assign b_ready_o = resetn & b_valid_i & (~a_valid_i | (ptr_q == REQ_B));

    assign wr_en   = a_ready_o | b_ready_o;
    assign wr_addr = b_ready_o ? b_addr_i    : a_addr_i;
    assign wr_be   = b_ready_o ? b_byteena_i : a_byteena_i;
    assign wr_data = b_ready_o ? b_data_i    : a_data_i;

    always_comb begin
        ptr_d = ptr_q;
        if (a_ready_o) begin
            ptr_d = REQ_B;
        end else if (b_ready_o) begin
            ptr_d = REQ_A;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (a_valid_i && b_valid_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Addresses with no matching word read as zero and write nowhere.
    always_comb begin
        rd_data_d = '0;
        for (int unsigned i = 0; i < N_WORDS; i++) begin
            if (rd_addr_i == ADDR_W'(i)) begin
                rd_data_d = word_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q     <= REQ_A;
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
        end
    end

    for (genvar g = 0; g < N_WORDS; g++) begin : gen_word
        byte_en_word #(
            .DATA_W (DATA_W)
        ) u_word (
            .clk       (clk),
            .resetn    (resetn),
            .we_i      (wr_en && (wr_addr == ADDR_W'(g))),
            .byteena_i (wr_be),
            .d_i       (wr_data),
            .q_o       (word_q[g])
        );
    end

    assign rd_data_o      = rd_data_q;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_byte_write_arbiter.sv
// Directed bench for byte_write_arbiter: writes, lane merging, arbitration order,
// read latency, counter saturation and mid-stream reset.
module tb_byte_write_arbiter;

    logic        clk;
    logic        resetn;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [1:0]  a_addr, b_addr, rd_addr;
    logic [1:0]  a_be, b_be;
    logic [15:0] a_data, b_data, rd_data;
    logic [7:0]  conflict_cnt;

    int errors = 0;
    int checks = 0;

    byte_write_arbiter dut (
        .clk            (clk),
        .resetn         (resetn),
        .a_valid_i      (a_valid),
        .a_ready_o      (a_ready),
        .a_addr_i       (a_addr),
        .a_byteena_i    (a_be),
        .a_data_i       (a_data),
        .b_valid_i      (b_valid),
        .b_ready_o      (b_ready),
        .b_addr_i       (b_addr),
        .b_byteena_i    (b_be),
        .b_data_i       (b_data),
        .rd_addr_i      (rd_addr),
        .rd_data_o      (rd_data),
        .conflict_cnt_o (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_addr = 0; a_be = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_be = 0; b_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        cyc();
        resetn = 1;
    endtask

    task automatic drive_write(input bit is_b, input logic [1:0] addr, input logic [1:0] be,
                               input logic [15:0] data, output logic rdy);
        if (is_b) begin
            b_valid = 1; b_addr = addr; b_be = be; b_data = data;
        end else begin
            a_valid = 1; a_addr = addr; a_be = be; a_data = data;
        end
        #1;
        rdy = is_b ? b_ready : a_ready;
        cyc();
        idle_inputs();
    endtask

    task automatic read_word(input logic [1:0] addr, output logic [15:0] data);
        rd_addr = addr;
        cyc();
        data = rd_data;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        idle_inputs();
        rd_addr = 0;
        resetn  = 0;
        a_valid = 1;
        b_valid = 1;
        cyc();
        cyc();
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got a=%b b=%b expected a=0 b=0", a_ready, b_ready);
        end
        checks++;
        if (conflict_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", conflict_cnt);
        end
        checks++;
        if (rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rd_data: got %h expected 0000", rd_data);
        end
        idle_inputs();
        resetn = 1;
        for (int i = 0; i < 4; i++) begin
            read_word(2'(i), d);
            checks++;
            if (d !== 16'h0000) begin
                errors++;
                $display("FAIL reset_word%0d: got %h expected 0000", i, d);
            end
        end
    endtask

    task automatic test_basic_write();
        logic        rdy;
        logic [15:0] d;
        do_reset();
        drive_write(1'b0, 2'd1, 2'b11, 16'hBEEF, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: got %b expected 1", rdy);
        end
        read_word(2'd1, d);
        checks++;
        if (d !== 16'hBEEF) begin
            errors++;
            $display("FAIL basic_word1: got %h expected beef", d);
        end
        for (int i = 0; i < 4; i++) begin
            if (i != 1) begin
                read_word(2'(i), d);
                checks++;
                if (d !== 16'h0000) begin
                    errors++;
                    $display("FAIL basic_other%0d: got %h expected 0000", i, d);
                end
            end
        end
    endtask

    task automatic test_partial_lanes();
        logic        rdy;
        logic [15:0] d;
        drive_write(1'b0, 2'd2, 2'b11, 16'h1234, rdy);
        drive_write(1'b1, 2'd2, 2'b01, 16'hFFAA, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL partial_b_ready: got %b expected 1", rdy);
        end
        read_word(2'd2, d);
        checks++;
        if (d !== 16'h12AA) begin
            errors++;
            $display("FAIL partial_word2: got %h expected 12aa", d);
        end
        drive_write(1'b0, 2'd2, 2'b10, 16'h56FF, rdy);
        read_word(2'd2, d);
        checks++;
        if (d !== 16'h56AA) begin
            errors++;
            $display("FAIL partial_hi_lane: got %h expected 56aa", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic        exp_a;
        do_reset();
        a_valid = 1; a_addr = 2'd0; a_be = 2'b11;
        b_valid = 1; b_addr = 2'd3; b_be = 2'b11;
        for (int i = 0; i < 4; i++) begin
            a_data = 16'h1100 + 16'(i);
            b_data = 16'h2200 + 16'(i);
            #1;
            exp_a = (i % 2 == 0);
            checks++;
            if (a_ready !== exp_a || b_ready !== !exp_a) begin
                errors++;
                $display("FAIL rr_grant%0d: got a=%b b=%b expected a=%b b=%b",
                         i, a_ready, b_ready, exp_a, !exp_a);
            end
            cyc();
        end
        idle_inputs();
        checks++;
        if (conflict_cnt !== 8'd4) begin
            errors++;
            $display("FAIL rr_cnt: got %0d expected 4", conflict_cnt);
        end
        read_word(2'd0, d);
        checks++;
        if (d !== 16'h1102) begin
            errors++;
            $display("FAIL rr_word0: got %h expected 1102", d);
        end
        read_word(2'd3, d);
        checks++;
        if (d !== 16'h2203) begin
            errors++;
            $display("FAIL rr_word3: got %h expected 2203", d);
        end
    endtask

    task automatic test_zero_byteena();
        logic        rdy;
        logic [15:0] d;
        do_reset();
        drive_write(1'b0, 2'd0, 2'b00, 16'hFFFF, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL zbe_ready: got %b expected 1", rdy);
        end
        a_valid = 1; a_addr = 2'd1; a_be = 2'b00; a_data = 16'hFFFF;
        b_valid = 1; b_addr = 2'd1; b_be = 2'b11; b_data = 16'h0B0B;
        #1;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL zbe_ptr: got a=%b b=%b expected a=0 b=1", a_ready, b_ready);
        end
        cyc();
        idle_inputs();
        read_word(2'd0, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL zbe_word0: got %h expected 0000", d);
        end
        read_word(2'd1, d);
        checks++;
        if (d !== 16'h0B0B) begin
            errors++;
            $display("FAIL zbe_word1: got %h expected 0b0b", d);
        end
    endtask

    task automatic test_no_bypass();
        logic rdy;
        do_reset();
        drive_write(1'b0, 2'd3, 2'b11, 16'h7777, rdy);
        rd_addr = 2'd3;
        a_valid = 1; a_addr = 2'd3; a_be = 2'b11; a_data = 16'h5555;
        cyc();
        idle_inputs();
        checks++;
        if (rd_data !== 16'h7777) begin
            errors++;
            $display("FAIL bypass_old: got %h expected 7777", rd_data);
        end
        cyc();
        checks++;
        if (rd_data !== 16'h5555) begin
            errors++;
            $display("FAIL bypass_new: got %h expected 5555", rd_data);
        end
    endtask

    task automatic test_saturate_and_reset();
        logic [15:0] d;
        do_reset();
        a_valid = 1; a_addr = 2'd1; a_be = 2'b11; a_data = 16'hA1A1;
        b_valid = 1; b_addr = 2'd2; b_be = 2'b11; b_data = 16'hB2B2;
        for (int i = 0; i < 300; i++) cyc();
        checks++;
        if (conflict_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_cnt: got %0d expected 255", conflict_cnt);
        end
        resetn = 0;
        a_be = 2'b00;
        b_be = 2'b00;
        #1;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL sat_rst_ready: got a=%b b=%b expected a=0 b=0", a_ready, b_ready);
        end
        cyc();
        resetn = 1;
        checks++;
        if (conflict_cnt !== 8'd0) begin
            errors++;
            $display("FAIL sat_rst_cnt: got %0d expected 0", conflict_cnt);
        end
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL sat_first_grant: got a=%b b=%b expected a=1 b=0", a_ready, b_ready);
        end
        cyc();
        #1;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_second_grant: got a=%b b=%b expected a=0 b=1", a_ready, b_ready);
        end
        cyc();
        idle_inputs();
        checks++;
        if (conflict_cnt !== 8'd2) begin
            errors++;
            $display("FAIL sat_restart_cnt: got %0d expected 2", conflict_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            read_word(2'(i), d);
            checks++;
            if (d !== 16'h0000) begin
                errors++;
                $display("FAIL sat_word%0d: got %h expected 0000", i, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_partial_lanes();
        test_back_to_back();
        test_zero_byteena();
        test_no_bypass();
        test_saturate_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/byte_write_arbiter.md
BYTE_WRITE_ARBITER -- requirements
Module: byte_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter N_WORDS, default 4: number of byte-writable words; ADDR_W = clog2(N_WORDS) = 2.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low; clock clk.
REQ-005 a_valid  input  1  requester A write request.
REQ-006 a_ready  output  1  requester A grant; the write completes on a cycle with a_valid & a_ready.
REQ-007 a_addr  input  ADDR_W  requester A target word.
REQ-008 a_byteena  input  DATA_W/8  requester A byte lanes; bit k enables bits [8k+7:8k].
REQ-009 a_data  input  DATA_W  requester A write data.
REQ-010 b_valid, b_ready, b_addr, b_byteena, b_data: identical widths and meaning for requester B.
REQ-011 rd_addr  input  ADDR_W  read word select.
REQ-012 rd_data  output  DATA_W  registered read data.
REQ-013 conflict_cnt  output  8  count of cycles where both requesters were valid, saturating.

Function
REQ-014 Grant SHALL be combinational: a_ready = resetn & a_valid & (!b_valid | ptr==A); b_ready = resetn & b_valid & (!a_valid | ptr==B).
REQ-015 At most one requester SHALL be granted per cycle; a_ready & b_ready SHALL never both be 1.
REQ-016 ptr SHALL be a one-bit round-robin pointer; after any granted write it SHALL point to the non-granted requester; with no grant it SHALL hold.
REQ-017 On a granted write, lanes with byteena bit 1 SHALL update from data at the next edge; lanes with bit 0 SHALL hold; no other word SHALL change.
REQ-018 byteena = 0 SHALL still complete the handshake and advance ptr, with no data change.
REQ-019 rd_data SHALL equal mem[rd_addr] as of before the edge, one-cycle latency; a same-cycle write to rd_addr SHALL NOT be bypassed (old data returned).
REQ-020 conflict_cnt SHALL increment by 1 on each cycle with a_valid & b_valid, saturating at 255.
REQ-021 Requesters SHALL hold addr/byteena/data stable while valid & !ready; the block SHALL NOT rely on valid deasserting after grant.
REQ-022 Out-of-range addresses cannot occur when N_WORDS is a power of two; otherwise writes to addr >= N_WORDS SHALL be accepted and discarded, and reads SHALL return 0.

Reset
REQ-023 While resetn = 0 at an edge: all words SHALL clear to 0, rd_data SHALL be 0, ptr SHALL be A, and conflict_cnt SHALL be 0.
REQ-024 While resetn = 0, a_ready and b_ready SHALL be 0, so no request is accepted.
REQ-025 Reset asserted while requests are pending SHALL drop them silently; requesters re-arbitrate from ptr = A after release.

Structure
REQ-026 A shared package byte_write_pkg SHALL hold DATA_W, N_WORDS, ADDR_W, and the requester-id enum (REQ_A, REQ_B).
REQ-027 Each word SHALL be one instance of sub-module byte_en_word: clk, resetn, we, byteena, d, q; it performs a synchronous clear and per-lane load.
REQ-028 Arbitration, write-port mux, and counter SHALL reside in the top level; there SHALL be no other sub-modules.

Verification
REQ-029 Reset, then A writes addr 1, byteena 11, data 0xBEEF; next cycle rd_addr = 1 -> rd_data = 0xBEEF one cycle later; other words remain 0.
REQ-030 A writes addr 2 with data 0x1234 (byteena 11), then B writes addr 2 with byteena 01 and data 0xFFAA -> word 2 = 0x12AA.
REQ-031 Both valid for 4 cycles from reset -> grants go A, B, A, B; conflict_cnt = 4.
REQ-032 A writes addr 0 with byteena 00 and data 0xFFFF -> a_ready = 1, word 0 stays 0x0000, and ptr moves to B.
REQ-033 Write 0x5555 to addr 3 while rd_addr = 3 in the same cycle -> rd_data shows the old value; the following cycle shows 0x5555.
REQ-034 Hold both valid for 300 cycles -> conflict_cnt = 255; then pulse resetn low for 1 cycle mid-stream -> all words 0, counter 0, next grant goes to A.
